// File: rtl/audio_bram_recorder.sv
// ---------------------------------------------------------------------------
// audio_bram_recorder
//
// Captures a single take of 8-bit unsigned audio samples into a BRAM. Each
// accepted sample_tick becomes one BRAM write on the following cycle. A take
// ends when the file fills (FILE_SIZE samples) or when stop is pulsed.
//
// Optional feature (macro REC_TRIGGER_EN):
//   When defined, start arms the recorder instead of recording at once. The
//   first tick whose magnitude about midscale 128 is at least THRESHOLD is
//   written to address 0 and recording begins. Quieter ticks are dropped.
//   When undefined, the ARMED state and the threshold compare are absent.
//
// Ports:
//   CLK          in   system clock
//   RESET_N      in   synchronous, active-low reset
//   sample_in    in   8-bit unsigned sample, midscale 128
//   sample_tick  in   one-cycle strobe, sample_in valid this cycle
//   start        in   one-cycle record request
//   stop         in   one-cycle abort/finish request
//   bram_addr    out  BRAM write address (holds between writes)
//   bram_din     out  BRAM write data
//   bram_we      out  BRAM write enable, one cycle per sample
//   busy         out  high while ARMED or RECORD
//   done         out  high while DONE
//   rec_length   out  samples written in the current/last take
//
// Handshake: sample_tick and start/stop are single-cycle strobes with no
// back-pressure; a tick accepted at a clock edge appears as bram_we=1 for
// exactly the next cycle, together with its address and data.
// ---------------------------------------------------------------------------
module audio_bram_recorder #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int FILE_SIZE     = 14996,
    parameter int THRESHOLD     = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [7:0]               sample_in,
    input  logic                     sample_tick,
    input  logic                     start,
    input  logic                     stop,
    output logic [ADDRESS_WIDTH-1:0] bram_addr,
    output logic [7:0]               bram_din,
    output logic                     bram_we,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   rec_length
);

`ifdef REC_TRIGGER_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RECORD = 2'd2,
        S_DONE   = 2'd3
    } state_t;
    localparam state_t START_STATE = S_ARMED;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd2,
        S_DONE   = 2'd3
    } state_t;
    localparam state_t START_STATE = S_RECORD;
`endif

    // Pointer is one bit wider than the address so it can reach FILE_SIZE
    // (the "file full" value) without wrapping back to 0.
    localparam logic [ADDRESS_WIDTH:0] LEN_FULL = (ADDRESS_WIDTH+1)'(FILE_SIZE);
    localparam logic [ADDRESS_WIDTH:0] PTR_ONE  = (ADDRESS_WIDTH+1)'(1);

    state_t                 state;
    logic [ADDRESS_WIDTH:0] wr_ptr;

`ifdef REC_TRIGGER_EN
    logic [7:0] magnitude;
    logic       loud;

    always_comb begin
        magnitude = (sample_in >= 8'd128) ? (sample_in - 8'd128) : (8'd128 - sample_in);
        loud      = (int'(magnitude) >= THRESHOLD);
    end
`endif

    // The pointer counts writes, so it doubles as the take length.
    assign rec_length = wr_ptr;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
            bram_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bram_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // start beats a simultaneous stop here because stop is
                    // simply not looked at in these states.
                    if (start) begin
                        state  <= START_STATE;
                        wr_ptr <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
`ifdef REC_TRIGGER_EN
                S_ARMED: begin
                    if (stop) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (sample_tick && loud) begin
                        // The triggering sample is the first one stored.
                        bram_we   <= 1'b1;
                        bram_din  <= sample_in;
                        bram_addr <= wr_ptr[ADDRESS_WIDTH-1:0];
                        wr_ptr    <= wr_ptr + PTR_ONE;
                        state     <= S_RECORD;
                    end
                end
`endif
                S_RECORD: begin
                    // A full pointer means the last address was written on
                    // the previous edge; close the take without writing.
                    // stop also wins over a tick in the same cycle.
                    if (stop || (wr_ptr == LEN_FULL)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (sample_tick) begin
                        bram_we   <= 1'b1;
                        bram_din  <= sample_in;
                        bram_addr <= wr_ptr[ADDRESS_WIDTH-1:0];
                        wr_ptr    <= wr_ptr + PTR_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_bram_recorder.sv
// ---------------------------------------------------------------------------
// tb_audio_bram_recorder
//
// Directed test of audio_bram_recorder with a small file (6 samples) and a
// 4-bit address. Expected BRAM writes are queued by the driver and popped by
// an independent monitor whenever bram_we is seen. With REC_TRIGGER_EN
// defined, an extra section exercises the sound-activated start.
// ---------------------------------------------------------------------------
module tb_audio_bram_recorder;

    localparam int AW = 4;
    localparam int FS = 6;
    localparam int TH = 16;

    logic          clk;
    logic          reset_n;
    logic [7:0]    sample_in;
    logic          sample_tick;
    logic          start;
    logic          stop;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;
    logic          bram_we;
    logic          busy;
    logic          done;
    logic [AW:0]   rec_length;

    logic [AW+7:0] exp_q[$];
    int            n_checks;
    int            n_fail;

    audio_bram_recorder #(
        .ADDRESS_WIDTH (AW),
        .FILE_SIZE     (FS),
        .THRESHOLD     (TH)
    ) dut (
        .CLK         (clk),
        .RESET_N     (reset_n),
        .sample_in   (sample_in),
        .sample_tick (sample_tick),
        .start       (start),
        .stop        (stop),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_we     (bram_we),
        .busy        (busy),
        .done        (done),
        .rec_length  (rec_length)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT makes must match the head of the queue.
    always @(negedge clk) begin
        logic [AW+7:0] e;
        if (bram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, no write expected (t=%0t)",
                         bram_addr, bram_din, $time);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bram_addr, e[AW+7:8]);
                check("write_data", bram_din, e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    // One tick; wr says whether a write must follow at address addr.
    task automatic tick(input logic [7:0] s, input bit wr, input int addr);
        logic [AW-1:0] a;
        a = addr[AW-1:0];
        sample_in   = s;
        sample_tick = 1'b1;
        if (wr) exp_q.push_back({a, s});
        step(1);
        sample_tick = 1'b0;
        check("we_after_tick", bram_we, wr);
    endtask

    task automatic check_outputs(input string tag, input int addr, input int b, input int d, input int len);
        check({tag, "_addr"}, bram_addr, addr);
        check({tag, "_busy"}, busy, b);
        check({tag, "_done"}, done, d);
        check({tag, "_len"}, rec_length, len);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        sample_in   = 8'd0;
        sample_tick = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        step(3);
        check("reset_we", bram_we, 0);
        check("reset_din", bram_din, 0);
        check_outputs("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        step(1);

        // Stop and ticks in IDLE are ignored.
        pulse_stop();
        check("idle_stop_done", done, 0);
        tick(8'd33, 0, 0);

        // Basic take: 10,20,30 -> addr 0,1,2, then stop.
        pulse_start();
        check_outputs("start1", 0, 1, 0, 0);
        tick(8'd10, 1, 0);
        check("len_after_1", rec_length, 1);
        step(1);
        tick(8'd20, 1, 1);
        tick(8'd30, 1, 2);
        step(2);
        check_outputs("hold", 2, 1, 0, 3);
        pulse_stop();
        check_outputs("stopped", 2, 0, 1, 3);
        tick(8'd40, 0, 0);
        pulse_stop();
        check_outputs("done_hold", 2, 0, 1, 3);

        // New take from DONE, start and stop together: start wins.
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check_outputs("restart", 2, 1, 0, 0);
        tick(8'd200, 1, 0);
        tick(8'd201, 1, 1);
        // stop together with a tick: the tick is dropped.
        sample_in   = 8'd202;
        sample_tick = 1'b1;
        stop        = 1'b1;
        step(1);
        sample_tick = 1'b0;
        stop        = 1'b0;
        check("stop_tick_we", bram_we, 0);
        check_outputs("stop_tick", 1, 0, 1, 2);

        // Fill the file; start mid-take is ignored; extra ticks dropped.
        pulse_start();
        tick(8'd50, 1, 0);
        pulse_start();
        check_outputs("start_ignored", 0, 1, 0, 1);
        for (int i = 1; i < FS; i++) tick(8'(50 + i), 1, i);
        check_outputs("last_write", FS - 1, 1, 0, FS);
        step(1);
        check_outputs("full", FS - 1, 0, 1, FS);
        tick(8'd56, 0, 0);
        tick(8'd57, 0, 0);
        check("full_len_hold", rec_length, FS);

        // Reset mid-take after five writes, with a tick in the reset cycle.
        pulse_start();
        for (int i = 0; i < 5; i++) tick(8'(60 + i), 1, i);
        reset_n     = 1'b0;
        sample_in   = 8'd70;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        reset_n     = 1'b1;
        check("rst_we", bram_we, 0);
        check("rst_din", bram_din, 0);
        check_outputs("rst", 0, 0, 0, 0);
        tick(8'd71, 0, 0);
        tick(8'd72, 0, 0);
        check("rst_len_after", rec_length, 0);

`ifdef REC_TRIGGER_EN
        // Sound-activated start: only |s-128| >= 16 fires.
        pulse_start();
        check_outputs("armed", 0, 1, 0, 0);
        tick(8'd128, 0, 0);
        tick(8'd135, 0, 0);
        tick(8'd121, 0, 0);
        check("armed_len", rec_length, 0);
        tick(8'd150, 1, 0);
        tick(8'd100, 1, 1);
        check_outputs("triggered", 1, 1, 0, 2);
        pulse_stop();
        pulse_start();
        tick(8'd143, 0, 0);
        tick(8'd112, 1, 0);
        check("edge_trigger_len", rec_length, 1);
        pulse_stop();
        check("edge_trigger_done", done, 1);
`endif

        step(3);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
